// File: rtl/pre_emphasis_pkg.sv
// Shared definitions for the pre-emphasis filter: filter coefficient shift,
// default sample geometry, default output buffer depth and the sample type.
package pe_pkg;

  // alpha = 1 - 2^-ALPHA_SHIFT = 31/32
  localparam int ALPHA_SHIFT       = 5;

  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_INT_BIT_WIDTH = 12;
  localparam int DEF_FRA_BIT_WIDTH = 0;
  localparam int DEF_DATAIN_WIDTH  = DEF_INT_BIT_WIDTH + DEF_FRA_BIT_WIDTH;

  typedef logic signed [DEF_DATAIN_WIDTH-1:0] sample_t;

endpackage

// File: rtl/pre_emphasis_if.sv
// Valid/ready stream carrying pre-emphasised samples to the downstream stage.
// The filter drives it through the master modport, the consumer through slave.
interface pe_if #(
  parameter int DATA_W = pe_pkg::DEF_DATAIN_WIDTH
) ();

  logic signed [DATA_W-1:0] pe_data;
  logic                     pe_valid;
  logic                     pe_ready;

  modport master (output pe_data, output pe_valid, input pe_ready);
  modport slave  (input pe_data, input pe_valid, output pe_ready);

endinterface

// File: rtl/pre_emphasis_fifo.sv
// pe_fifo: synchronous output buffer for the pre-emphasis filter.
// Read data is shown combinationally at the head and forced to zero when empty.
// A write into a full buffer is only accepted when a read frees the head slot
// in the same cycle; otherwise it is ignored and the contents stay untouched.
module pe_fifo import pe_pkg::*; #(
  parameter int DATA_W = DEF_DATAIN_WIDTH,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wrEn,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic                     i_rdEn,
  output logic [DATA_W-1:0]        o_rdData,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              w_doRead;
  logic              w_doWrite;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdData  = o_empty ? '0 : r_mem[r_rdPtr];
  assign w_doRead  = i_rdEn & ~o_empty;
  assign w_doWrite = i_wrEn & (~o_full | w_doRead);

  // Storage array: written only on an accepted write, never reset
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doWrite) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doRead)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doWrite, w_doRead})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pre_emphasis.sv
// pre_emphasis: first-order pre-emphasis filter y = x - x_prev + (x_prev >>> 5)
// on I2S samples, buffered into a small FIFO towards a valid/ready consumer.
// Pipeline: capture on the LRCLK rising edge (N), full-precision sum (N+1),
// width reduction and FIFO write (N+2), output visible at N+3.
// Build option: define PRE_EMPH_SAT_EN to clamp the result to the sample range;
// without it the result wraps to its low DATAIN_WIDTH bits.
module pre_emphasis import pe_pkg::*; #(
  parameter int Input_INT_BIT_WIDTH = DEF_INT_BIT_WIDTH,
  parameter int Input_FRA_BIT_WIDTH = DEF_FRA_BIT_WIDTH,
  parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH
) (
  input  logic MCLK,
  input  logic MCLK_rst,
  input  logic fe_en,
  input  logic LRCLK,
  input  logic signed [Input_INT_BIT_WIDTH+Input_FRA_BIT_WIDTH-1:0] audio_data,
  pe_if.master pe_out,
  output logic overflow
);

  localparam int DATAIN_WIDTH = Input_INT_BIT_WIDTH + Input_FRA_BIT_WIDTH;
  localparam int YW           = DATAIN_WIDTH + 2;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic                           r_lrD;
  logic                           r_s1Valid;
  logic signed [DATAIN_WIDTH-1:0] r_x;
  logic signed [DATAIN_WIDTH-1:0] r_xCapPrev;
  logic signed [DATAIN_WIDTH-1:0] r_xPrev;
  logic                           r_s2Valid;
  logic signed [YW-1:0]           r_y;
  logic                           r_overflow;

  logic                           w_sampleStb;
  logic signed [DATAIN_WIDTH-1:0] w_xpShift;
  logic signed [YW-1:0]           w_xExt;
  logic signed [YW-1:0]           w_xpExt;
  logic signed [YW-1:0]           w_shExt;
  logic signed [YW-1:0]           w_yFull;
  logic signed [DATAIN_WIDTH-1:0] w_yRed;
  logic                           w_fifoWr;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_drop;
  logic [CW-1:0]                  w_fifoCount;
  logic [DATAIN_WIDTH-1:0]        w_rdData;

  assign w_sampleStb = LRCLK & ~r_lrD & fe_en;

  // Full-precision sum: two guard bits cover |x - x_prev| plus the leak term
  assign w_xpShift = r_xCapPrev >>> ALPHA_SHIFT;
  assign w_xExt    = {{2{r_x[DATAIN_WIDTH-1]}}, r_x};
  assign w_xpExt   = {{2{r_xCapPrev[DATAIN_WIDTH-1]}}, r_xCapPrev};
  assign w_shExt   = {{2{w_xpShift[DATAIN_WIDTH-1]}}, w_xpShift};
  assign w_yFull   = w_xExt - w_xpExt + w_shExt;

`ifdef PRE_EMPH_SAT_EN
  localparam logic signed [YW-1:0] SAT_MAX = {3'b000, {(DATAIN_WIDTH-1){1'b1}}};
  localparam logic signed [YW-1:0] SAT_MIN = {3'b111, {(DATAIN_WIDTH-1){1'b0}}};

  // Clamp the wide result into the signed sample range
  always_comb begin
    w_yRed = DATAIN_WIDTH'(r_y);
    if (r_y > SAT_MAX) begin
      w_yRed = SAT_MAX[DATAIN_WIDTH-1:0];
    end else if (r_y < SAT_MIN) begin
      w_yRed = SAT_MIN[DATAIN_WIDTH-1:0];
    end
  end
`else
  assign w_yRed = DATAIN_WIDTH'(r_y);
`endif

  // Write is suppressed while disabled so an in-flight sample never lands
  assign w_fifoWr = r_s2Valid & fe_en;
  assign w_drop   = w_fifoWr & w_full & ~pe_out.pe_ready;

  assign pe_out.pe_valid = ~w_empty;
  assign pe_out.pe_data  = w_rdData;
  assign overflow        = r_overflow;

  // LRCLK edge detector history
  always_ff @(posedge MCLK or posedge MCLK_rst) begin
    if (MCLK_rst) r_lrD <= 1'b0;
    else          r_lrD <= LRCLK;
  end

  // Stage 1: capture the new sample with the history value it pairs with
  always_ff @(posedge MCLK or posedge MCLK_rst) begin
    if (MCLK_rst) begin
      r_s1Valid  <= 1'b0;
      r_x        <= '0;
      r_xCapPrev <= '0;
    end else begin
      r_s1Valid <= w_sampleStb;
      if (w_sampleStb) begin
        r_x        <= audio_data;
        r_xCapPrev <= r_xPrev;
      end
    end
  end

  // Stage 2: register the sum and advance history; disabling flushes both
  always_ff @(posedge MCLK or posedge MCLK_rst) begin
    if (MCLK_rst) begin
      r_s2Valid <= 1'b0;
      r_y       <= '0;
      r_xPrev   <= '0;
    end else if (!fe_en) begin
      r_s2Valid <= 1'b0;
      r_xPrev   <= '0;
    end else begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_y     <= w_yFull;
        r_xPrev <= r_x;
      end
    end
  end

  // Sticky drop indicator, cleared only by reset
  always_ff @(posedge MCLK or posedge MCLK_rst) begin
    if (MCLK_rst)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  pe_fifo #(
    .DATA_W (DATAIN_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (MCLK),
    .rst      (MCLK_rst),
    .i_wrEn   (w_fifoWr),
    .i_wrData (w_yRed),
    .i_rdEn   (pe_out.pe_ready),
    .o_rdData (w_rdData),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_fifoCount)
  );

  // Occupancy can never exceed the buffer depth
  assert property (@(posedge MCLK) disable iff (MCLK_rst) w_fifoCount <= CW'(FIFO_DEPTH));

endmodule
